shifter_seq: RTL and testbench

Parametrised, multi-cycle shifter for the datapath. It takes an operand of WIDTH bits and a full shift amount, then shifts left or right, logical or arithmetic, moving at most STEP bit positions per clock. Start, busy and done signals sequence each operation. It generalises the single-bit combinational right shifter to any shift amount, both directions and an optional rotate mode, and trades latency for area in the ALU's shift path.

---
 rtl/shifter_seq.sv | 79 +++++++
 tb/tb_shifter_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle shifter moving up to STEP bits per clock; rotate mode only with SHIFTER_ROTATE_EN
module shifter_seq #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH),
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             arith,
    input  logic             rot,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] data, data_sh;
    logic [SHW-1:0] cnt, k, amt;
    logic ldir, fill, accept, finish;
`ifdef SHIFTER_ROTATE_EN
    logic lrot;
`else
    logic unused_rot;
    assign unused_rot = rot;
`endif
    assign amt = (32'(shamt) > WIDTH - 1) ? SHW'(WIDTH - 1) : shamt;
    assign busy = state == SHIFT;
    always_comb begin
        k = (32'(cnt) < STEP) ? cnt : SHW'(STEP);
        // fill already folds in arith and the operand MSB captured at accept
        data_sh = ldir ? data << k : (data >> k) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> k));
`ifdef SHIFTER_ROTATE_EN
        if (lrot)
            data_sh = ldir ? (data << k) | (data >> (WIDTH - 32'(k))) : (data >> k) | (data << (WIDTH - 32'(k)));
`endif
        accept = start && state != SHIFT;
        finish = state == SHIFT && cnt == k;
        state_n = accept ? (amt == '0 ? DONE : SHIFT) :
                  state == SHIFT ? (finish ? DONE : SHIFT) :
                  IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data <= '0;
            cnt <= '0;
            ldir <= 1'b0;
            fill <= 1'b0;
`ifdef SHIFTER_ROTATE_EN
            lrot <= 1'b0;
`endif
            done <= 1'b0;
            z <= '0;
        end else begin
            state <= state_n;
            done <= accept ? amt == '0 : finish;
            if (accept) begin
                data <= x;
                cnt <= amt;
                ldir <= dir;
                fill <= arith & x[WIDTH-1];
`ifdef SHIFTER_ROTATE_EN
                lrot <= rot;
`endif
            end else if (state == SHIFT) begin
                data <= data_sh;
                cnt <= cnt - k;
            end
            if (accept && amt == '0)
                z <= x;
            else if (finish)
                z <= data_sh;
        end
    end
endmodule

// File: tb/tb_shifter_seq.sv
// tb_shifter_seq: checks shifter_seq at STEP=1 and STEP=4 against an arithmetic reference model
module tb_shifter_seq;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0, arith = 1'b0, rot = 1'b0;
    logic [31:0] x = '0;
    logic [4:0] shamt = '0;
    logic busy1, done1, busy4, done4;
    logic [31:0] z1, z4;
    int n_cmp = 0, n_fail = 0;
    logic [31:0] zd [2], zf [2];
    int di [2], dn [2], bc [2];
`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    shifter_seq #(.WIDTH(32), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .x(x), .shamt(shamt), .dir(dir),
        .arith(arith), .rot(rot), .busy(busy1), .done(done1), .z(z1)
    );
    shifter_seq #(.WIDTH(32), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .x(x), .shamt(shamt), .dir(dir),
        .arith(arith), .rot(rot), .busy(busy4), .done(done4), .z(z4)
    );

    function automatic logic [31:0] model(input logic [31:0] v, input int s, input logic d, input logic a, input logic r);
        if (r && ROT_EN)
            return d ? (v << s) | (v >> (32 - s)) : (v >> s) | (v << (32 - s));
        if (d)
            return v << s;
        return a ? 32'($signed(v) >>> s) : v >> s;
    endfunction

    task automatic do_op(input logic [31:0] v, input int s, input logic d, input logic a, input logic r);
        logic [1:0] bo, dq;
        logic [31:0] zo [2];
        @(negedge clk);
        x = v; shamt = 5'(s); dir = d; arith = a; rot = r; start = 1'b1;
        for (int u = 0; u < 2; u++) begin
            di[u] = 0; dn[u] = 0; bc[u] = 0; zd[u] = 'x;
        end
        for (int c = 1; c <= s + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            bo = {busy4, busy1}; dq = {done4, done1}; zo[0] = z1; zo[1] = z4;
            for (int u = 0; u < 2; u++) begin
                bc[u] += int'(bo[u]);
                if (dq[u]) begin
                    dn[u]++;
                    if (dn[u] == 1) begin
                        di[u] = c;
                        zd[u] = zo[u];
                    end
                end
            end
        end
        zf[0] = z1; zf[1] = z4;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy1, done1, z1} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset step1: got busy=%b done=%b z=%h want all 0", busy1, done1, z1);
        end
        n_cmp++;
        if ({busy4, done4, z4} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset step4: got busy=%b done=%b z=%h want all 0", busy4, done4, z4);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] tx [8] = '{32'h0000000A, 32'h80000000, 32'h80000000, 32'h80000000,
                                32'h00000001, 32'h12345678, 32'h00000001, 32'hF0000001};
        int ts [8] = '{1, 4, 4, 4, 9, 0, 1, 31};
        logic [2:0] tm [8] = '{3'b000, 3'b010, 3'b000, 3'b110, 3'b100, 3'b000, 3'b001, 3'b011};
        logic [31:0] te [8] = '{32'h00000005, 32'hF8000000, 32'h08000000, 32'h00000000,
                                32'h00000200, 32'h12345678, ROT_EN ? 32'h80000000 : 32'h0,
                                ROT_EN ? 32'hE0000003 : 32'hFFFFFFFF};
        int n;
        for (int i = 0; i < 8; i++) begin
            do_op(tx[i], ts[i], tm[i][2], tm[i][1], tm[i][0]);
            for (int u = 0; u < 2; u++) begin
                n = u ? (ts[i] + 3) / 4 : ts[i];
                n_cmp += 5;
                if (zd[u] !== te[i]) begin n_fail++; $display("FAIL dir%0d z u%0d: got %h want %h", i, u, zd[u], te[i]); end
                if (zf[u] !== te[i]) begin n_fail++; $display("FAIL dir%0d z_hold u%0d: got %h want %h", i, u, zf[u], te[i]); end
                if (di[u] != n + 1) begin n_fail++; $display("FAIL dir%0d done_cycle u%0d: got %0d want %0d", i, u, di[u], n + 1); end
                if (dn[u] != 1) begin n_fail++; $display("FAIL dir%0d done_count u%0d: got %0d want 1", i, u, dn[u]); end
                if (bc[u] != n) begin n_fail++; $display("FAIL dir%0d busy_cycles u%0d: got %0d want %0d", i, u, bc[u], n); end
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] v, e;
        int s, n;
        logic d, a, r;
        for (int i = 0; i < 24; i++) begin
            v = $urandom; s = $urandom_range(0, 31);
            d = 1'($urandom); a = 1'($urandom); r = 1'($urandom);
            e = model(v, s, d, a, r);
            do_op(v, s, d, a, r);
            for (int u = 0; u < 2; u++) begin
                n = u ? (s + 3) / 4 : s;
                n_cmp += 4;
                if (zd[u] !== e) begin n_fail++; $display("FAIL rnd%0d z u%0d: got %h want %h", i, u, zd[u], e); end
                if (di[u] != n + 1) begin n_fail++; $display("FAIL rnd%0d done_cycle u%0d: got %0d want %0d", i, u, di[u], n + 1); end
                if (dn[u] != 1) begin n_fail++; $display("FAIL rnd%0d done_count u%0d: got %0d want 1", i, u, dn[u]); end
                if (bc[u] != n) begin n_fail++; $display("FAIL rnd%0d busy_cycles u%0d: got %0d want %0d", i, u, bc[u], n); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int c;
        @(negedge clk);
        x = 32'h00ABCD00; shamt = 5'd8; dir = 1'b0; arith = 1'b0; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        x = 32'hFFFFFFFF; shamt = 5'd3; dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (done1 !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        n_cmp += 2;
        if (done1 !== 1'b1) begin n_fail++; $display("FAIL b2b first_done: got %b want 1", done1); end
        if (z1 !== 32'h0000ABCD) begin n_fail++; $display("FAIL b2b ignore_start z: got %h want 0000abcd", z1); end
        x = 32'h00000003; shamt = 5'd2; dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp += 3;
        if (done1 !== 1'b0) begin n_fail++; $display("FAIL b2b done_drop: got %b want 0", done1); end
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b accept_in_done busy: got %b want 1", busy1); end
        if (z1 !== 32'h0000ABCD) begin n_fail++; $display("FAIL b2b z_hold: got %h want 0000abcd", z1); end
        c = 0;
        while (done1 !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_cmp += 2;
        if (c != 2) begin n_fail++; $display("FAIL b2b second_latency: got %0d want 2", c); end
        if (z1 !== 32'h0000000C) begin n_fail++; $display("FAIL b2b second_z: got %h want 0000000c", z1); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen1, seen4;
        @(negedge clk);
        x = 32'h87654321; shamt = 5'd20; dir = 1'b0; arith = 1'b1; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp += 2;
        if ({busy1, done1, z1} !== 34'd0) begin n_fail++; $display("FAIL rst_mid step1: got busy=%b done=%b z=%h want all 0", busy1, done1, z1); end
        if ({busy4, done4, z4} !== 34'd0) begin n_fail++; $display("FAIL rst_mid step4: got busy=%b done=%b z=%h want all 0", busy4, done4, z4); end
        seen1 = 0; seen4 = 0;
        repeat (30) begin
            @(negedge clk);
            seen1 += int'(done1);
            seen4 += int'(done4);
        end
        n_cmp += 2;
        if (seen1 != 0) begin n_fail++; $display("FAIL rst_mid aborted_done step1: got %0d pulses want 0", seen1); end
        if (seen4 != 0) begin n_fail++; $display("FAIL rst_mid aborted_done step4: got %0d pulses want 0", seen4); end
        do_op(32'h0000000A, 1, 1'b0, 1'b0, 1'b0);
        for (int u = 0; u < 2; u++) begin
            n_cmp += 2;
            if (zd[u] !== 32'h5) begin n_fail++; $display("FAIL rst_mid fresh_z u%0d: got %h want 00000005", u, zd[u]); end
            if (di[u] != 2) begin n_fail++; $display("FAIL rst_mid fresh_done_cycle u%0d: got %0d want 2", u, di[u]); end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
